// File: rtl/out_uart_pkg.sv
// Shared types and constants for the byte-output UART transmitter.
package out_uart_pkg;

    localparam int   DATA_W      = 8;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

endpackage

// File: rtl/out_uart_tx_if.sv
// Byte-output port (data + toggle strobe) and UART-side status, grouped for the transmitter.
interface out_uart_tx_if
    import out_uart_pkg::*;
#(
    parameter int FIFO_AW = 4
);
    logic [DATA_W-1:0] in_dat;
    logic              in_ctl;
    logic              txd;
    logic              busy;
    logic              overflow;
    logic [FIFO_AW:0]  level;

    modport master (output in_dat, in_ctl, input txd, busy, overflow, level);
    modport slave  (input in_dat, in_ctl, output txd, busy, overflow, level);
endinterface

// File: rtl/out_fifo.sv
// Single-clock FIFO with first-word-fall-through read; a push into a full FIFO is accepted only with a same-cycle pop.
module out_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);
    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          w_wr_en;
    logic          w_rd_en;

    assign full    = r_level[AW];
    assign empty   = (r_level == '0);
    assign w_rd_en = pop & ~empty;
    assign w_wr_en = push & (~full | w_rd_en);
    assign dout    = r_mem[r_rd_ptr];
    assign level   = r_level;

    // NOTE: storage has no reset; occupancy is tracked by the pointers and level alone.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr_en, w_rd_en})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/out_uart_tx.sv
// Toggle-strobe byte sink that queues bytes and sends them as UART frames (8N1, or 8E1 when OUT_UART_PARITY_EN is defined).
module out_uart_tx
    import out_uart_pkg::*;
#(
    parameter int CLK_DIV = 217,
    parameter int FIFO_AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    out_uart_tx_if.slave  bus
);
    localparam int               CNT_W   = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic              r_ctl_q;
    logic              r_overflow;
    logic              r_txd;
    state_t            r_state,  w_state_nxt;
    logic [CNT_W-1:0]  r_cnt,    w_cnt_nxt;
    logic [2:0]        r_bitcnt, w_bitcnt_nxt;
    logic [DATA_W-1:0] r_shreg,  w_shreg_nxt;
    logic              w_txd_nxt;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_bit_end;
    logic [DATA_W-1:0] w_dout;
    logic [FIFO_AW:0]  w_level;
`ifdef OUT_UART_PARITY_EN
    logic              r_par, w_par_nxt;
`endif

    assign w_push    = bus.in_ctl ^ r_ctl_q;
    assign w_bit_end = (r_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctl_q    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_ctl_q <= bus.in_ctl;
            if (w_push & w_full & ~w_pop) r_overflow <= 1'b1;
        end
    end

    out_fifo #(
        .DW (DATA_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (bus.in_dat),
        .pop   (w_pop),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    // txd is the registered line level of the current state, so it trails the state by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_bitcnt <= '0;
            r_shreg  <= '0;
            r_txd    <= IDLE_LEVEL;
`ifdef OUT_UART_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shreg  <= w_shreg_nxt;
            r_txd    <= w_txd_nxt;
`ifdef OUT_UART_PARITY_EN
            r_par    <= w_par_nxt;
`endif
        end
    end

    // NOTE: combinational block uses blocking assignments, with every output defaulted first so no latch is inferred.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_bitcnt_nxt = r_bitcnt;
        w_shreg_nxt  = r_shreg;
        w_txd_nxt    = IDLE_LEVEL;
        w_pop        = 1'b0;
`ifdef OUT_UART_PARITY_EN
        w_par_nxt    = r_par;
`endif
        if (r_state != IDLE) begin
            w_cnt_nxt = w_bit_end ? CNT_MAX : r_cnt - CNT_W'(1);
        end

        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shreg_nxt  = w_dout;
                    w_bitcnt_nxt = '0;
                    w_cnt_nxt    = CNT_MAX;
                    w_state_nxt  = START;
`ifdef OUT_UART_PARITY_EN
                    w_par_nxt    = ^w_dout;
`endif
                end
            end
            START: begin
                w_txd_nxt = START_LEVEL;
                if (w_bit_end) w_state_nxt = DATA;
            end
            DATA: begin
                w_txd_nxt = r_shreg[0];
                if (w_bit_end) begin
                    w_shreg_nxt  = r_shreg >> 1;
                    w_bitcnt_nxt = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
`ifdef OUT_UART_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef OUT_UART_PARITY_EN
            PARITY: begin
                w_txd_nxt = r_par;
                if (w_bit_end) w_state_nxt = STOP;
            end
`endif
            STOP: begin
                w_txd_nxt = IDLE_LEVEL;
                if (w_bit_end) w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.txd      = r_txd;
    assign bus.busy     = (r_state != IDLE) | ~w_empty;
    assign bus.overflow = r_overflow;
    assign bus.level    = w_level;

endmodule

// File: tb/tb_out_uart_tx.sv
// Directed bench for out_uart_tx with a frame-decoding monitor and expected-byte scoreboard queue.
module tb_out_uart_tx;

    localparam int BD    = 4;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
`ifdef OUT_UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    out_uart_tx_if #(.FIFO_AW(AW)) bus ();

    out_uart_tx #(
        .CLK_DIV (BD),
        .FIFO_AW (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q [$];
    int         gap_q [$];
    logic       par_q [$];
    int         n_frames   = 0;
    int         cyc        = 0;
    int         last_start = 0;
    logic       m_act  = 1'b0;
    logic       m_prev = 1'b1;
    int         m_t    = 0;
    logic [7:0] m_sh   = '0;
    logic       m_par  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Frame decoder: samples each bit one cycle into its period.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            m_act  = 1'b0;
            m_prev = 1'b1;
        end else begin
            if (!m_act) begin
                if (m_prev && !bus.txd) begin
                    m_act = 1'b1;
                    m_t   = 0;
                    gap_q.push_back(cyc - last_start);
                    last_start = cyc;
                end
            end else begin
                m_t++;
                if (m_t == 1) begin
                    check("start_bit", bus.txd, 1'b0);
                end else if (m_t % BD == 1) begin
                    if (m_t / BD >= 1 && m_t / BD <= 8) m_sh[m_t / BD - 1] = bus.txd;
                    else if (m_t / BD == NB - 1) check("stop_bit", bus.txd, 1'b1);
`ifdef OUT_UART_PARITY_EN
                    else if (m_t / BD == 9) m_par = bus.txd;
`endif
                end
                if (m_t == BD * NB - 1) begin
                    check("stop_end", bus.txd, 1'b1);
                    n_frames++;
                    check("frame_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) check("frame_data", m_sh, exp_q.pop_front());
`ifdef OUT_UART_PARITY_EN
                    check("frame_parity", m_par, ^m_sh);
                    par_q.push_back(m_par);
`endif
                    m_act = 1'b0;
                end
            end
            m_prev = bus.txd;
        end
    end

    task automatic toggle(input logic [7:0] b, input bit accept);
        bus.in_dat = b;
        bus.in_ctl = ~bus.in_ctl;
        if (accept) exp_q.push_back(b);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string tag, output int peak);
        bit done;
        done = 1'b0;
        peak = int'(bus.level);
        for (int i = 0; i < 800 && !done; i++) begin
            @(posedge clk); #1;
            if (int'(bus.level) > peak) peak = int'(bus.level);
            if (!bus.busy && !m_act && bus.txd === 1'b1) done = 1'b1;
        end
        check({tag, "_idle"}, done, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int peak;
        int f0;
        bus.in_ctl = 1'b0;
        bus.in_dat = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd", bus.txd, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_overflow", bus.overflow, 1'b0);
        check("rst_level", bus.level, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single byte: latency and bit pattern
        toggle(8'h55, 1'b1);
        check("t1_level_write", bus.level, 1);
        check("t1_txd_idle", bus.txd, 1'b1);
        @(posedge clk); #1;
        check("t1_level_pop", bus.level, 0);
        check("t1_busy", bus.busy, 1'b1);
        check("t1_txd_still_high", bus.txd, 1'b1);
        @(posedge clk); #1;
        check("t1_txd_fall", bus.txd, 1'b0);
        wait_idle("t1", peak);
        check("t1_busy_done", bus.busy, 1'b0);
        check("t1_frames", n_frames, 1);

        // Three consecutive strobes
        f0 = n_frames;
        gap_q.delete();
        toggle(8'h41, 1'b1);
        toggle(8'h42, 1'b1);
        toggle(8'h43, 1'b1);
        wait_idle("t2", peak);
        check("t2_peak_level", peak, 2);
        check("t2_frames", n_frames - f0, 3);
        check("t2_gap_count", gap_q.size(), 3);
        check("t2_gap1", gap_q[1], BD * NB + 1);
        check("t2_gap2", gap_q[2], BD * NB + 1);
        check("t2_overflow", bus.overflow, 1'b0);

        // Push into a full FIFO on the same edge as a pop
        f0 = n_frames;
        toggle(8'h10, 1'b1);
        toggle(8'h11, 1'b1);
        toggle(8'h12, 1'b1);
        toggle(8'h13, 1'b1);
        toggle(8'h14, 1'b1);
        check("t6_full", bus.level, DEPTH);
        repeat (BD * NB - 3) begin
            @(posedge clk); #1;
        end
        check("t6_full_before", bus.level, DEPTH);
        toggle(8'h15, 1'b1);
        check("t6_level_hold", bus.level, DEPTH);
        check("t6_overflow", bus.overflow, 1'b0);
        wait_idle("t6", peak);
        check("t6_frames", n_frames - f0, 6);
        check("t6_queue_empty", exp_q.size(), 0);

        // Overflow: six strobes while idle, last one dropped
        f0 = n_frames;
        toggle(8'h20, 1'b1);
        toggle(8'h21, 1'b1);
        toggle(8'h22, 1'b1);
        toggle(8'h23, 1'b1);
        toggle(8'h24, 1'b1);
        check("t3_level_full", bus.level, DEPTH);
        check("t3_no_overflow_yet", bus.overflow, 1'b0);
        toggle(8'h25, 1'b0);
        check("t3_overflow", bus.overflow, 1'b1);
        check("t3_level_after_drop", bus.level, DEPTH);
        wait_idle("t3", peak);
        check("t3_frames", n_frames - f0, 5);
        check("t3_queue_empty", exp_q.size(), 0);
        check("t3_overflow_sticky", bus.overflow, 1'b1);

        // Reset during data bit 3
        toggle(8'hA5, 1'b1);
        repeat (19) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        bus.in_ctl = 1'b0;
        exp_q.delete();
        #1;
        check("t4_txd", bus.txd, 1'b1);
        check("t4_busy", bus.busy, 1'b0);
        check("t4_level", bus.level, 0);
        check("t4_overflow", bus.overflow, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        f0 = n_frames;
        @(posedge clk); #1;
        check("t4_txd_after", bus.txd, 1'b1);
        check("t4_busy_after", bus.busy, 1'b0);
        toggle(8'h3C, 1'b1);
        wait_idle("t4", peak);
        check("t4_frames", n_frames - f0, 1);
        check("t4_queue_empty", exp_q.size(), 0);

        // Frame length and parity bytes
        f0 = n_frames;
        gap_q.delete();
        par_q.delete();
        toggle(8'h07, 1'b1);
        toggle(8'h03, 1'b1);
        wait_idle("t5", peak);
        check("t5_frames", n_frames - f0, 2);
        check("t5_frame_len", gap_q[1], BD * NB + 1);
`ifdef OUT_UART_PARITY_EN
        check("t5_par_count", par_q.size(), 2);
        check("t5_par_07", par_q[0], 1'b1);
        check("t5_par_03", par_q[1], 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
